// File: rtl/exmem_stage_reg.sv
// rtl/exmem_stage_reg.sv - EX/MEM pipeline register with store lane steering and active-low bit-write mask
module exmem_stage_reg #(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             EXE_valid,
  input  logic [XLEN-1:0]  ALU_out,
  input  logic [4:0]       EXE_write_addr,
  input  logic [2:0]       EXE_funct3,
  input  logic [XLEN-1:0]  EXE_pc,
  input  logic [XLEN-1:0]  EXE_memory_in,
  input  logic             EXE_RDSrc,
  input  logic             EXE_MemtoReg,
  input  logic             EXE_MemWrite,
  input  logic             EXE_MemRead,
  input  logic             EXE_RegWrite,
  output logic             MEM_valid,
  output logic [XLEN-1:0]  MEM_ALU_out,
  output logic [XLEN-1:0]  MEM_pc,
  output logic [4:0]       MEM_write_addr,
  output logic [2:0]       MEM_funct3,
  output logic [XLEN-1:0]  MEM_memory_in,
  output logic [XLEN-1:0]  MEM_MemWrite,
  output logic             MEM_RDSrc,
  output logic             MEM_MemtoReg,
  output logic             MEM_MemRead,
  output logic             MEM_RegWrite,
  output logic [OFF_W-1:0] MEM_byte_off,
  output logic             MEM_store_fault
);

  logic             valid_q, rdsrc_q, memtoreg_q, memread_q, regwrite_q, fault_q;
  logic [XLEN-1:0]  alu_q, pc_q, mem_in_q, mask_q;
  logic [4:0]       waddr_q;
  logic [2:0]       funct3_q;
  logic [OFF_W-1:0] off_q;

  logic [XLEN-1:0]  mem_in_d, mask_d;
  logic             fault_d;
  logic             legal, store_ok;
  int               off_i, nb;

  // A store is legal only when its size fits the word and its offset is size-aligned.
  always_comb begin
    off_i    = int'(ALU_out[OFF_W-1:0]);
    nb       = 1 << int'(EXE_funct3[1:0]);
    legal    = (nb <= XLEN/8) && ((off_i & (nb - 1)) == 0);
    store_ok = EXE_MemWrite && legal;
    fault_d  = EXE_MemWrite && !legal;
    mem_in_d = store_ok ? (EXE_memory_in << (8 * off_i)) : EXE_memory_in;
    mask_d   = '1;
    if (store_ok) begin
      for (int i = 0; i < XLEN/8; i++) begin
        if (i >= off_i && i < off_i + nb) mask_d[8*i +: 8] = 8'h00;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush || (!stall && !EXE_valid)) begin
      valid_q    <= 1'b0;
      alu_q      <= '0;
      pc_q       <= '0;
      waddr_q    <= '0;
      funct3_q   <= '0;
      mem_in_q   <= '0;
      mask_q     <= '1;
      rdsrc_q    <= 1'b0;
      memtoreg_q <= 1'b0;
      memread_q  <= 1'b0;
      regwrite_q <= 1'b0;
      off_q      <= '0;
      fault_q    <= 1'b0;
    end else if (!stall) begin
      valid_q    <= 1'b1;
      alu_q      <= ALU_out;
      pc_q       <= EXE_pc;
      waddr_q    <= EXE_write_addr;
      funct3_q   <= EXE_funct3;
      mem_in_q   <= mem_in_d;
      mask_q     <= mask_d;
      rdsrc_q    <= EXE_RDSrc;
      memtoreg_q <= EXE_MemtoReg;
      memread_q  <= EXE_MemRead;
      regwrite_q <= EXE_RegWrite;
      off_q      <= ALU_out[OFF_W-1:0];
      fault_q    <= fault_d;
    end
  end

  assign MEM_valid       = valid_q;
  assign MEM_ALU_out     = alu_q;
  assign MEM_pc          = pc_q;
  assign MEM_write_addr  = waddr_q;
  assign MEM_funct3      = funct3_q;
  assign MEM_memory_in   = mem_in_q;
  assign MEM_MemWrite    = mask_q;
  assign MEM_RDSrc       = rdsrc_q;
  assign MEM_MemtoReg    = memtoreg_q;
  assign MEM_MemRead     = memread_q;
  assign MEM_RegWrite    = regwrite_q;
  assign MEM_byte_off    = off_q;
  assign MEM_store_fault = fault_q;

endmodule

// File: tb/tb_exmem_stage_reg.sv
// tb/tb_exmem_stage_reg.sv - checks XLEN=32 and XLEN=64 instances against a byte-level reference model
module tb_exmem_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, flush, valid;
  logic [63:0] alu, pc, mdat;
  logic [4:0]  waddr;
  logic [2:0]  f3;
  logic        rdsrc, m2r, mw, mr, rw;

  logic        a_valid, a_rdsrc, a_m2r, a_mr, a_rw, a_fault;
  logic [31:0] a_alu, a_pc, a_mi, a_mask;
  logic [4:0]  a_wa;
  logic [2:0]  a_f3;
  logic [1:0]  a_off;

  logic        b_valid, b_rdsrc, b_m2r, b_mr, b_rw, b_fault;
  logic [63:0] b_alu, b_pc, b_mi, b_mask;
  logic [4:0]  b_wa;
  logic [2:0]  b_f3;
  logic [2:0]  b_off;

  exmem_stage_reg #(.XLEN(32)) u32 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .EXE_valid(valid),
    .ALU_out(alu[31:0]), .EXE_write_addr(waddr), .EXE_funct3(f3), .EXE_pc(pc[31:0]),
    .EXE_memory_in(mdat[31:0]), .EXE_RDSrc(rdsrc), .EXE_MemtoReg(m2r), .EXE_MemWrite(mw),
    .EXE_MemRead(mr), .EXE_RegWrite(rw),
    .MEM_valid(a_valid), .MEM_ALU_out(a_alu), .MEM_pc(a_pc), .MEM_write_addr(a_wa),
    .MEM_funct3(a_f3), .MEM_memory_in(a_mi), .MEM_MemWrite(a_mask), .MEM_RDSrc(a_rdsrc),
    .MEM_MemtoReg(a_m2r), .MEM_MemRead(a_mr), .MEM_RegWrite(a_rw), .MEM_byte_off(a_off),
    .MEM_store_fault(a_fault)
  );

  exmem_stage_reg #(.XLEN(64)) u64 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .EXE_valid(valid),
    .ALU_out(alu), .EXE_write_addr(waddr), .EXE_funct3(f3), .EXE_pc(pc),
    .EXE_memory_in(mdat), .EXE_RDSrc(rdsrc), .EXE_MemtoReg(m2r), .EXE_MemWrite(mw),
    .EXE_MemRead(mr), .EXE_RegWrite(rw),
    .MEM_valid(b_valid), .MEM_ALU_out(b_alu), .MEM_pc(b_pc), .MEM_write_addr(b_wa),
    .MEM_funct3(b_f3), .MEM_memory_in(b_mi), .MEM_MemWrite(b_mask), .MEM_RDSrc(b_rdsrc),
    .MEM_MemtoReg(b_m2r), .MEM_MemRead(b_mr), .MEM_RegWrite(b_rw), .MEM_byte_off(b_off),
    .MEM_store_fault(b_fault)
  );

  int checks = 0;
  int errors = 0;

  // Expected state per instance: index 0 is XLEN=32, index 1 is XLEN=64.
  logic        e_valid[2], e_rdsrc[2], e_m2r[2], e_mr[2], e_rw[2], e_fault[2];
  logic [63:0] e_alu[2], e_pc[2], e_mi[2], e_mask[2];
  logic [4:0]  e_wa[2];
  logic [2:0]  e_f3[2], e_off[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_bubble(input int k);
    e_valid[k] = 0; e_alu[k] = 0; e_pc[k] = 0; e_wa[k] = 0; e_f3[k] = 0; e_mi[k] = 0;
    e_mask[k] = (k == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    e_rdsrc[k] = 0; e_m2r[k] = 0; e_mr[k] = 0; e_rw[k] = 0; e_off[k] = 0; e_fault[k] = 0;
  endtask

  task automatic model_update(input int k);
    int nbytes, off, sz;
    logic [127:0] wmask, lane, data;
    nbytes = (k == 1) ? 8 : 4;
    wmask  = (k == 1) ? 128'hFFFF_FFFF_FFFF_FFFF : 128'hFFFF_FFFF;
    if (reset || flush || (!stall && !valid)) model_bubble(k);
    else if (!stall) begin
      off = int'(alu % nbytes);
      sz  = 2 ** int'(f3[1:0]);
      e_valid[k] = 1; e_alu[k] = alu & wmask[63:0]; e_pc[k] = pc & wmask[63:0];
      e_wa[k] = waddr; e_f3[k] = f3; e_off[k] = 3'(off);
      e_rdsrc[k] = rdsrc; e_m2r[k] = m2r; e_mr[k] = mr; e_rw[k] = rw;
      e_mi[k] = mdat & wmask[63:0]; e_mask[k] = wmask[63:0]; e_fault[k] = 0;
      if (mw) begin
        if (sz <= nbytes && off % sz == 0) begin
          lane = ((128'd1 << (8 * sz)) - 1) << (8 * off);
          data = (128'(mdat) & wmask) << (8 * off);
          e_mi[k] = 64'(data & wmask);
          e_mask[k] = 64'(wmask & ~lane);
        end else e_fault[k] = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".a_valid"}, 64'(a_valid), 64'(e_valid[0]));
    chk({tag, ".a_alu"},   64'(a_alu),   e_alu[0]);
    chk({tag, ".a_pc"},    64'(a_pc),    e_pc[0]);
    chk({tag, ".a_wa"},    64'(a_wa),    64'(e_wa[0]));
    chk({tag, ".a_f3"},    64'(a_f3),    64'(e_f3[0]));
    chk({tag, ".a_mi"},    64'(a_mi),    e_mi[0]);
    chk({tag, ".a_mask"},  64'(a_mask),  e_mask[0]);
    chk({tag, ".a_ctl"},   64'({a_rdsrc, a_m2r, a_mr, a_rw}),
        64'({e_rdsrc[0], e_m2r[0], e_mr[0], e_rw[0]}));
    chk({tag, ".a_off"},   64'(a_off),   64'(e_off[0]));
    chk({tag, ".a_fault"}, 64'(a_fault), 64'(e_fault[0]));
    chk({tag, ".b_valid"}, 64'(b_valid), 64'(e_valid[1]));
    chk({tag, ".b_alu"},   b_alu,        e_alu[1]);
    chk({tag, ".b_pc"},    b_pc,         e_pc[1]);
    chk({tag, ".b_wa"},    64'(b_wa),    64'(e_wa[1]));
    chk({tag, ".b_f3"},    64'(b_f3),    64'(e_f3[1]));
    chk({tag, ".b_mi"},    b_mi,         e_mi[1]);
    chk({tag, ".b_mask"},  b_mask,       e_mask[1]);
    chk({tag, ".b_ctl"},   64'({b_rdsrc, b_m2r, b_mr, b_rw}),
        64'({e_rdsrc[1], e_m2r[1], e_mr[1], e_rw[1]}));
    chk({tag, ".b_off"},   64'(b_off),   64'(e_off[1]));
    chk({tag, ".b_fault"}, 64'(b_fault), 64'(e_fault[1]));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
    check_all(tag);
  endtask

  task automatic rand_inputs();
    alu   = {$urandom, $urandom};
    pc    = {$urandom, $urandom};
    mdat  = {$urandom, $urandom};
    waddr = 5'($urandom);
    f3    = 3'($urandom);
    {rdsrc, m2r, mw, mr, rw} = 5'($urandom);
    valid = 1'b1;
  endtask

  task automatic store(input logic [2:0] fn, input logic [63:0] addr, input logic [63:0] d);
    rand_inputs();
    reset = 0; stall = 0; flush = 0; valid = 1; mw = 1; f3 = fn; alu = addr; mdat = d;
  endtask

  initial begin
    model_bubble(0);
    model_bubble(1);
    rand_inputs();
    reset = 1; stall = 0; flush = 0;
    step("reset0");
    step("reset1");
    chk("reset_mask", 64'(a_mask), 64'hFFFF_FFFF);
    reset = 0; stall = 1;
    for (int i = 0; i < 2; i++) begin
      rand_inputs();
      step("reset_hold");
      chk("reset_hold_mask", 64'(a_mask), 64'hFFFF_FFFF);
      chk("reset_hold_valid", 64'(a_valid), 64'd0);
    end

    store(3'b000, 64'h1003, 64'h0000_00AB);
    step("sb");
    chk("sb_data", 64'(a_mi), 64'hAB00_0000);
    chk("sb_mask", 64'(a_mask), 64'h00FF_FFFF);
    chk("sb_fault", 64'(a_fault), 64'd0);
    store(3'b001, 64'h1002, 64'h1234);
    step("sh");
    chk("sh_data", 64'(a_mi), 64'h1234_0000);
    chk("sh_mask", 64'(a_mask), 64'h0000_FFFF);

    store(3'b010, 64'h1002, 64'h55);
    step("sw_mis");
    chk("sw_mis_mask", 64'(a_mask), 64'hFFFF_FFFF);
    chk("sw_mis_fault", 64'(a_fault), 64'd1);
    store(3'b011, 64'h1000, 64'h0123_4567_89AB_CDEF);
    step("sd");
    chk("sd32_fault", 64'(a_fault), 64'd1);
    chk("sd64_mask", b_mask, 64'h0);
    store(3'b010, 64'h1004, 64'hDEAD_BEEF);
    step("sw64");
    chk("sw64_data", b_mi, 64'hDEAD_BEEF_0000_0000);
    chk("sw64_mask", b_mask, 64'h0000_0000_FFFF_FFFF);

    store(3'b010, 64'h1000, 64'hCAFE_F00D);
    step("sw0");
    chk("sw0_mask", 64'(a_mask), 64'h0);
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      stall = 1;
      step("stall");
      chk("stall_mask", 64'(a_mask), 64'h0);
    end
    rand_inputs();
    stall = 1; flush = 1;
    step("stall_flush");
    chk("sf_valid", 64'(a_valid), 64'd0);
    chk("sf_mask", 64'(a_mask), 64'hFFFF_FFFF);
    chk("sf_rw", 64'(a_rw), 64'd0);

    rand_inputs();
    stall = 0; flush = 0; valid = 0; mw = 1; rw = 1;
    step("bubble");
    chk("bubble_mask", 64'(a_mask), 64'hFFFF_FFFF);
    chk("bubble_rw", 64'(a_rw), 64'd0);
    chk("bubble_valid", 64'(a_valid), 64'd0);
    store(3'b000, 64'h2001, 64'h77);
    step("pre_reset");
    rand_inputs();
    stall = 1; reset = 1;
    step("reset_stall");
    chk("rs_valid", 64'(a_valid), 64'd0);
    chk("rs_mask", 64'(b_mask), 64'hFFFF_FFFF_FFFF_FFFF);

    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      alu[2:0] = (($urandom % 4) == 0) ? 3'(alu[5:3]) : 3'b000;
      valid = ($urandom % 8) != 0;
      reset = ($urandom % 50) == 0;
      flush = ($urandom % 10) == 0;
      stall = ($urandom % 5) == 0;
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exmem_stage_reg.md
Name: exmem_stage_reg

Overview:
Parametrised EX/MEM pipeline register for the CPU core. It carries EX results and control into MEM and generalises datapath width to XLEN=32 or 64. It builds the store-lane data and the active-low bit-write mask for the data SRAM. Beyond a plain register it adds stall/flush handling, a valid bit, misaligned/unsupported store detection and a load byte offset for MEM-stage extraction.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
OFF_W, $clog2(XLEN/8), width of the byte offset within a word.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
stall  in  1  hold all outputs.
flush  in  1  insert bubble.
EXE_valid  in  1  EX stage holds a real instruction.
ALU_out  in  XLEN  effective address / ALU result.
EXE_write_addr  in  5  rd.
EXE_funct3  in  3  load/store width code.
EXE_pc  in  XLEN  instruction PC.
EXE_memory_in  in  XLEN  rs2 store data, LSB-aligned.
EXE_RDSrc, EXE_MemtoReg, EXE_MemWrite, EXE_MemRead, EXE_RegWrite  in  1 each  control.
MEM_valid  out  1  registered valid.
MEM_ALU_out, MEM_pc  out  XLEN  registered.
MEM_write_addr  out  5;  MEM_funct3  out  3.
MEM_memory_in  out  XLEN  lane-shifted store data.
MEM_MemWrite  out  XLEN  bit-write mask, active-low (0 = write bit).
MEM_RDSrc, MEM_MemtoReg, MEM_MemRead, MEM_RegWrite  out  1 each.
MEM_byte_off  out  OFF_W  ALU_out[OFF_W-1:0], for the MEM load aligner.
MEM_store_fault  out  1  store dropped: misaligned or unsupported width.

Behaviour:
- Priority per posedge clk: reset > flush > stall > normal load. Latency is 1 cycle.
- Reset:
  - all outputs 0, except MEM_MemWrite = all ones.
  - No write is ever enabled out of reset.
- Flush (stall ignored):
  - MEM_valid, MEM_RegWrite, MEM_MemRead and MEM_store_fault = 0.
  - MEM_MemWrite = all ones.
  - Data fields (ALU_out, pc, write_addr, funct3, memory_in, byte_off) = 0.
- Stall, no flush: every output holds its value, including MEM_MemWrite and MEM_store_fault.
- Normal load with EXE_valid=0: same as flush. A bubble never writes memory or registers.
- Normal load with EXE_valid=1:
  - All pass-through fields are registered.
  - MEM_byte_off = ALU_out[OFF_W-1:0].
- Store (EXE_MemWrite=1), with off = ALU_out[OFF_W-1:0] and size code funct3[1:0]:
  - Sizes: 00=byte, 01=half, 10=word, 11=double (double only legal when XLEN=64).
  - Size in bytes: B = 1<<funct3[1:0].
  - Legal when B <= XLEN/8 and off % B == 0.
  - Legal: MEM_memory_in = EXE_memory_in << (8*off). MEM_MemWrite bits [8*off, 8*(off+B)-1] = 0, all other bits 1. MEM_store_fault = 0.
  - Illegal: MEM_MemWrite = all ones, MEM_memory_in = EXE_memory_in unshifted, MEM_store_fault = 1. MEM_RegWrite still follows the input.
  - funct3[2] is ignored for stores.
- Non-store:
  - MEM_MemWrite = all ones.
  - MEM_memory_in = EXE_memory_in unshifted.
  - MEM_store_fault = 0.
- Shifts are truncated to XLEN; no bits wrap to the LSB end.
- Reset asserted mid-stall clears state on the next edge regardless of stall.
- Simultaneous stall and flush resolve to flush.

Test Plan:
1. XLEN=32, reset=1 for 2 cycles, then stall=1 -> all outputs 0, MEM_MemWrite=32'hFFFF_FFFF, and values held while stalled.
2. XLEN=32, SB: ALU_out=32'h1003, data=32'h0000_00AB -> next cycle MEM_memory_in=32'hAB00_0000, MEM_MemWrite=32'h00FF_FFFF, fault=0. Repeat with SH at off=2, data=32'h1234 -> memory_in=32'h1234_0000, mask=32'h0000_FFFF.
3. XLEN=32, SW at ALU_out=32'h1002 -> mask=32'hFFFF_FFFF, fault=1. funct3=011 (SD) at off=0 -> fault=1.
4. XLEN=64, SD at off=0 -> mask=64'h0. SW at off=4, data=32'hDEADBEEF -> memory_in=64'hDEADBEEF_0000_0000, mask=64'h0000_0000_FFFF_FFFF.
5. Load SW at off=0 (mask=32'h0), then stall=1 for 3 cycles with changing inputs -> mask stays 32'h0, all outputs unchanged. Next cycle stall=1, flush=1 -> MEM_valid=0, mask all ones, RegWrite=0.
6. EXE_valid=0 with EXE_MemWrite=1 and EXE_RegWrite=1 -> MEM_MemWrite all ones, MEM_RegWrite=0, MEM_valid=0. Assert reset during a stall -> cleared on the next edge.
